// File: rtl/signed_narrow_sat_if.sv
// Valid/ready stream bundle for the saturating narrower: a wide sample with
// its signedness flag in, a narrow signed result plus a clip flag out.
interface signed_narrow_sat_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic        [IN_W-1:0]  in_data;
  logic                    in_signed;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  // Producer/consumer side (drives samples in, takes results out).
  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // Block side.
  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/signed_narrow_sat.sv
// Saturating narrower: clips a wide signed or unsigned sample into a narrow
// two's-complement range, one registered output slot with valid/ready on both
// sides, and a sticky-at-max counter of clipped samples for debug.
// IN_W must exceed OUT_W, and OUT_W must be at least 2.
module signed_narrow_sat #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  signed_narrow_sat_if.slave bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_count
);

  // Range limits, held one bit wider than the input so an unsigned sample
  // with its MSB set still compares as a large positive number.
  localparam logic signed [IN_W:0]    MAX_X   = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0]    MIN_X   = (IN_W+1)'(-(2**(OUT_W-1)));
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic        [CNT_W-1:0] CNT_TOP = '1;

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] q;
  } sat_res_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  function automatic sat_res_t narrow_sat(input logic [IN_W-1:0] d,
                                          input logic            is_signed);
    logic signed [IN_W:0] v;
    sat_res_t             r;
    v     = is_signed ? $signed({d[IN_W-1], d}) : $signed({1'b0, d});
    r.sat = 1'b0;
    r.q   = v[OUT_W-1:0];
    if (v > MAX_X) begin
      r.sat = 1'b1;
      r.q   = OUT_MAX;
    end else if (v < MIN_X) begin
      r.sat = 1'b1;
      r.q   = OUT_MIN;
    end
    return r;
  endfunction

  state_t                  state_p1;
  state_t                  state_nxt;
  logic                    vld_p1;
  logic signed [OUT_W-1:0] data_p1;
  logic                    sat_p1;
  sat_res_t                res_p0;
  logic                    acc_p0;
  logic        [CNT_W-1:0] cnt_p1;

  // ---- stage p0: combinational clip of the offered sample ----
  assign vld_p1       = (state_p1 == FULL);
  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign acc_p0       = bus.in_valid && bus.in_ready;
  assign res_p0       = narrow_sat(bus.in_data, bus.in_signed);

  // ---- stage p1: output slot and event counter ----
  // Slot occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p1 <= EMPTY;
    else     state_p1 <= state_nxt;
  end

  // Slot fills on accept, drains when the consumer takes it with nothing new.
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY:   if (acc_p0) state_nxt = FULL;
      FULL:    if (bus.out_ready && !acc_p0) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Result captured only on accept so a stalled output holds still.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= '0;
      sat_p1  <= 1'b0;
    end else if (acc_p0) begin
      data_p1 <= res_p0.q;
      sat_p1  <= res_p0.sat;
    end
  end

  // Clip counter: clear wins but still counts a clip accepted that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (clr_cnt) begin
      cnt_p1 <= (acc_p0 && res_p0.sat) ? CNT_W'(1) : '0;
    end else if (acc_p0 && res_p0.sat && (cnt_p1 != CNT_TOP)) begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_sat   = sat_p1;
  assign sat_count     = cnt_p1;

endmodule

// File: tb/tb_signed_narrow_sat.sv
// Bench for signed_narrow_sat at IN_W=5, OUT_W=3, CNT_W=8.
module tb_signed_narrow_sat;
  localparam int IN_W  = 5;
  localparam int OUT_W = 3;
  localparam int CNT_W = 8;
  localparam int MAXV  = 2**(OUT_W-1) - 1;
  localparam int MINV  = -(2**(OUT_W-1));
  localparam int CTOP  = 2**CNT_W - 1;

  logic             clk;
  logic             rst;
  logic             clr_cnt;
  logic [CNT_W-1:0] sat_count;
  int               n_cmp;
  int               n_err;

  signed_narrow_sat_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  signed_narrow_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_cnt   (clr_cnt),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret the sample as a plain integer and clip to [MINV, MAXV].
  function automatic void ref_sat(input logic [IN_W-1:0] d, input logic sgn,
                                  output logic [OUT_W-1:0] q, output logic s);
    int v;
    v = int'(d);
    if (sgn && v >= 2**(IN_W-1)) v = v - 2**IN_W;
    if (v > MAXV)      begin q = OUT_W'(MAXV); s = 1'b1; end
    else if (v < MINV) begin q = OUT_W'(MINV); s = 1'b1; end
    else               begin q = OUT_W'(v);    s = 1'b0; end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cnt();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    clr_cnt       = 1'b1;
    tick();
    clr_cnt       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_cnt = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_signed = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 3'b000) begin n_err++; $display("FAIL reset_data: got %b want 000", bus.out_data); end
    n_cmp++; if (bus.out_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", bus.out_sat); end
    n_cmp++; if (sat_count !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", sat_count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_signed();
    logic [4:0] td [6] = '{5'b01010, 5'b10000, 5'b00011, 5'b00100, 5'b11100, 5'b11011};
    logic [2:0] tq [6] = '{3'b011,   3'b100,   3'b011,   3'b011,   3'b100,   3'b100};
    logic       ts [6] = '{1'b1,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
    int exp_cnt;
    clear_cnt();
    bus.in_valid = 1'b1; bus.in_data = 5'b11110; bus.in_signed = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL signed_m2_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 3'b110) begin n_err++; $display("FAIL signed_m2_data: got %b want 110", bus.out_data); end
    n_cmp++; if (bus.out_sat !== 1'b0) begin n_err++; $display("FAIL signed_m2_sat: got %b want 0", bus.out_sat); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL signed_one_cycle: got %b want 0", bus.out_valid); end
    exp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_data = td[i]; bus.in_signed = 1'b1;
      tick();
      if (ts[i]) exp_cnt++;
      n_cmp++; if (bus.out_data !== tq[i] || bus.out_sat !== ts[i] || bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL signed_tab%0d: got v=%b d=%b s=%b want v=1 d=%b s=%b", i, bus.out_valid, bus.out_data, bus.out_sat, tq[i], ts[i]);
      end
      n_cmp++; if (sat_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL signed_cnt%0d: got %0d want %0d", i, sat_count, exp_cnt); end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    logic [4:0] td [6] = '{5'b11110, 5'b00010, 5'b10000, 5'b00011, 5'b00100, 5'b11111};
    logic [2:0] tq [6] = '{3'b011,   3'b010,   3'b011,   3'b011,   3'b011,   3'b011};
    logic       ts [6] = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1};
    clear_cnt();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_data = td[i]; bus.in_signed = 1'b0; bus.out_ready = 1'b1;
      tick();
      n_cmp++; if (bus.out_data !== tq[i] || bus.out_sat !== ts[i] || bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL unsigned_tab%0d: got v=%b d=%b s=%b want v=1 d=%b s=%b", i, bus.out_valid, bus.out_data, bus.out_sat, tq[i], ts[i]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_cmp++; if (sat_count !== 8'd4) begin n_err++; $display("FAIL unsigned_cnt: got %0d want 4", sat_count); end
  endtask

  task automatic test_stall();
    clear_cnt();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 5'b00001; bus.in_signed = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready_empty: got %b want 1", bus.in_ready); end
    tick();
    bus.in_data = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready%0d: got %b want 0", i, bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 3'b001) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b d=%b want v=1 d=001", i, bus.out_valid, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready_release: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 3'b111 || bus.out_sat !== 1'b0) begin
      n_err++; $display("FAIL stall_b_out: got v=%b d=%b s=%b want v=1 d=111 s=0", bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_dup: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_count_sat();
    clear_cnt();
    bus.in_valid = 1'b1; bus.in_data = 5'b01111; bus.in_signed = 1'b1; bus.out_ready = 1'b1;
    repeat (260) tick();
    bus.in_valid = 1'b0;
    tick();
    n_cmp++; if (sat_count !== 8'd255) begin n_err++; $display("FAIL cnt_stick: got %0d want 255", sat_count); end
    clr_cnt = 1'b1; bus.in_valid = 1'b1; bus.in_data = 5'b00001;
    tick();
    n_cmp++; if (sat_count !== 8'd0) begin n_err++; $display("FAIL cnt_clr_plain: got %0d want 0", sat_count); end
    bus.in_data = 5'b01111;
    tick();
    clr_cnt = 1'b0; bus.in_valid = 1'b0;
    n_cmp++; if (sat_count !== 8'd1) begin n_err++; $display("FAIL cnt_clr_clip: got %0d want 1", sat_count); end
    tick();
  endtask

  task automatic test_random();
    logic             m_vld;
    logic [OUT_W-1:0] m_data;
    logic             m_sat;
    int               m_cnt;
    logic [OUT_W-1:0] q;
    logic             s;
    logic             acc;
    logic             exp_rdy;
    clear_cnt();
    m_vld = 1'b0; m_data = '0; m_sat = 1'b0; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = IN_W'($urandom);
      bus.in_signed = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt       = ($urandom_range(0, 31) == 0);
      #1;
      exp_rdy = !m_vld || bus.out_ready;
      n_cmp++; if (bus.in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready%0d: got %b want %b", i, bus.in_ready, exp_rdy); end
      acc = bus.in_valid && exp_rdy;
      ref_sat(bus.in_data, bus.in_signed, q, s);
      if (clr_cnt)                      m_cnt = (acc && s) ? 1 : 0;
      else if (acc && s && m_cnt < CTOP) m_cnt++;
      if (acc) begin m_vld = 1'b1; m_data = q; m_sat = s; end
      else if (bus.out_ready) m_vld = 1'b0;
      tick();
      n_cmp++; if (bus.out_valid !== m_vld) begin n_err++; $display("FAIL rnd_valid%0d: got %b want %b", i, bus.out_valid, m_vld); end
      if (m_vld) begin
        n_cmp++; if (bus.out_data !== m_data || bus.out_sat !== m_sat) begin
          n_err++; $display("FAIL rnd_data%0d: got d=%b s=%b want d=%b s=%b", i, bus.out_data, bus.out_sat, m_data, m_sat);
        end
      end
      n_cmp++; if (sat_count !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt%0d: got %0d want %0d", i, sat_count, m_cnt); end
    end
    clr_cnt = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    clear_cnt();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 5'b10001; bus.in_signed = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 3'b100 || sat_count !== 8'd1) begin
      n_err++; $display("FAIL arst_pre: got v=%b d=%b c=%0d want v=1 d=100 c=1", bus.out_valid, bus.out_data, sat_count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 3'b000 || bus.out_sat !== 1'b0) begin
      n_err++; $display("FAIL arst_data: got d=%b s=%b want d=000 s=0", bus.out_data, bus.out_sat);
    end
    n_cmp++; if (sat_count !== 8'd0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", sat_count); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_after: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_signed();
    test_unsigned();
    test_stall();
    test_count_sat();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
